ym_bus_writer: RTL and testbench
================================

Name: ym_bus_writer

Overview:
Host-side initiator for the YM2151-compatible asynchronous CPU bus that the synth core presents (cs_n, wr_n, rd_n, a0, 8-bit data, status bit 7 = busy). It accepts one register write (address, data) per valid/ready handshake and performs a full bus sequence with programmable timing:
- busy poll
- address write (a0=0)
- busy poll
- data write (a0=1)

It is used by bench stimulus and by the on-board sequencer to drive the core exactly as a real host CPU would.

Parameters:
SETUP_CYC, 2, clk cycles with cs_n low and a0/data valid before the strobe; range 1..255
PULSE_CYC, 4, clk cycles the wr_n/rd_n strobe is held low; range 1..255
HOLD_CYC, 2, clk cycles after the strobe rises with cs_n low and a0/data held; range 1..255
RECOVER_CYC, 4, clk cycles with the bus fully idle after each bus cycle; range 1..255
MAX_POLLS, 64, maximum status reads per poll phase before abort; range 1..255

Ports:
clk        input   1  system clock
rst        input   1  synchronous, active-high reset
req_valid  input   1  write request valid
req_ready  output  1  block idle and able to accept
req_addr   input   8  YM register address
req_data   input   8  YM register data
done       output  1  one-cycle pulse at the end of each accepted request, whether completed or aborted
err_timeout output 1  one-cycle pulse coincident with done when the request was aborted by a poll timeout
cs_n       output  1  bus chip select, active low
wr_n       output  1  bus write strobe, active low
rd_n       output  1  bus read strobe, active low
a0         output  1  bus address line
data_out   output  8  bus write data
data_oe    output  1  high while the block drives the data bus
data_in    input   8  bus read data; bit 7 = busy

Behaviour:
- Reset values: req_ready=0 during rst, then 1 in IDLE. done=0, err_timeout=0, cs_n=1, wr_n=1, rd_n=1, a0=0, data_out=0, data_oe=0.
- Reset mid-operation: the next cycle returns all bus outputs to their reset values. The pending request is dropped and no done pulse is issued.
- Handshake:
  - req_ready=1 only in IDLE.
  - On a clk edge with req_valid&req_ready, req_addr and req_data are latched and the FSM leaves IDLE. req_ready=0 from the next cycle.
  - Changes on the req_* inputs after acceptance have no effect.
- Top-level phases, in order: POLL1 -> WADDR -> POLL2 -> WDATA -> FINISH -> IDLE.
- Every phase is built from one bus cycle, consisting of the sub-states SETUP(SETUP_CYC), STROBE(PULSE_CYC), HOLD(HOLD_CYC), RECOVER(RECOVER_CYC).
  - A single 8-bit down-counter is loaded on each sub-state entry.
  - One bus cycle lasts exactly S+P+H+R clks.
- Write cycle (WADDR: a0=0, data_out=addr; WDATA: a0=1, data_out=data):
  - cs_n=0, data_oe=1 and a0/data_out stable through SETUP, STROBE and HOLD.
  - wr_n=0 only in STROBE.
  - In RECOVER, cs_n=1 and data_oe=0; a0 and data_out hold their last value.
- Read (poll) cycle:
  - a0=1 and data_oe=0 throughout; cs_n=0 in SETUP, STROBE and HOLD.
  - rd_n=0 only in STROBE.
  - data_in[7] is sampled on the last STROBE clk.
- Poll phase:
  - Sampled busy=0: proceed to the next phase after RECOVER.
  - Sampled busy=1: repeat the read cycle.
  - A poll counter counts reads within the phase and is reset at phase entry.
  - If the MAX_POLLS-th read still shows busy=1: after its RECOVER, go to FINISH with abort flagged; remaining phases are skipped.
- FINISH lasts one cycle:
  - done=1; err_timeout=abort flag.
  - The next state is IDLE, with req_ready=1 from the cycle after FINISH.
  - A new request can be accepted on the first IDLE cycle; there is no back-to-back acceptance during FINISH.
- Latency with busy always 0 and default params:
  - Acceptance edge at cycle 0.
  - Bus activity in cycles 1..48 (4 bus cycles of 12 clks).
  - done in cycle 49; req_ready high in cycle 50.
  - Generally 4*(S+P+H+R)+1 cycles to done.
- Glitch-free outputs: cs_n, wr_n, rd_n, a0 and data_oe are registered, never decoded combinationally. wr_n and rd_n are never low simultaneously.
- Parameter value 1 in any field yields a 1-clk sub-state; there is no zero-length sub-state.

Test Plan:
- Reset, then idle 10 cycles -> cs_n=wr_n=rd_n=1, data_oe=0, req_ready=1, done=0 throughout.
- Single request addr=0x20, data=0xC7, data_in=0x00, default params:
  - wr_n low in cycles 15..18 with a0=0, data_out=0x20.
  - wr_n low in cycles 39..42 with a0=1, data_out=0xC7.
  - rd_n low in cycles 3..6 and 27..30.
  - done in cycle 49, err_timeout=0.
- Busy held at data_in=0x80 for the first 3 polls of POLL2, then 0x00 -> POLL2 spans 4 read cycles (48 clks); done in cycle 85.
- Busy stuck at 0x80, MAX_POLLS=3 -> 3 reads in POLL1, no wr_n pulse at all, done with err_timeout=1 in cycle 37.
- rst asserted during WADDR STROBE (cycle 16) -> cs_n=wr_n=1 and data_oe=0 on cycle 17, no done pulse; a new request after rst starts cleanly from POLL1.
- req_valid held high with 3 queued values, SETUP=PULSE=HOLD=RECOVER=1:
  - Each request is accepted only in IDLE and completes in 17 cycles to done.
  - Exactly 3 done pulses; no overlap of bus cycles.

Source files
------------

// File: rtl/ym_bus_writer_if.sv
// Request handshake plus YM2151-style asynchronous CPU bus between the writer (master)
// and its requester / synth core (slave).
interface ym_bus_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       done;
    logic       err_timeout;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    modport master (
        input  req_valid, req_addr, req_data, data_in,
        output req_ready, done, err_timeout, cs_n, wr_n, rd_n, a0, data_out, data_oe
    );

    modport slave (
        output req_valid, req_addr, req_data, data_in,
        input  req_ready, done, err_timeout, cs_n, wr_n, rd_n, a0, data_out, data_oe
    );
endinterface

// File: rtl/ym_bus_writer.sv
// Host-side initiator: each accepted request becomes busy-poll, address write, busy-poll,
// data write on the YM2151 CPU bus, with programmable setup/strobe/hold/recover timing.
module ym_bus_writer #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 4,
    parameter int unsigned MAX_POLLS   = 64
) (
    input logic            clk,
    input logic            rst,
    ym_bus_writer_if.master bus
);

    // Bus phases are numbered in execution order so a completed phase advances by +1.
    localparam logic [2:0] PhIdle   = 3'd0;
    localparam logic [2:0] PhPoll1  = 3'd1;
    localparam logic [2:0] PhWaddr  = 3'd2;
    localparam logic [2:0] PhPoll2  = 3'd3;
    localparam logic [2:0] PhWdata  = 3'd4;
    localparam logic [2:0] PhFinish = 3'd5;

    localparam logic [1:0] SubSetup   = 2'd0;
    localparam logic [1:0] SubStrobe  = 2'd1;
    localparam logic [1:0] SubHold    = 2'd2;
    localparam logic [1:0] SubRecover = 2'd3;

    localparam logic [7:0] SetupLd   = 8'(SETUP_CYC);
    localparam logic [7:0] PulseLd   = 8'(PULSE_CYC);
    localparam logic [7:0] HoldLd    = 8'(HOLD_CYC);
    localparam logic [7:0] RecoverLd = 8'(RECOVER_CYC);
    localparam logic [7:0] MaxPolls  = 8'(MAX_POLLS);

    logic [2:0] phase_q, phase_d;
    logic [1:0] sub_q, sub_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] poll_q, poll_d;
    logic       busy_q, busy_d;
    logic       abort_q, abort_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic       req_ready_q, req_ready_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       a0_q, a0_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;

    logic in_poll;
    assign in_poll = (phase_q == PhPoll1) || (phase_q == PhPoll2);

    // Only the busy flag of the status byte matters.
    logic unused_status;
    assign unused_status = ^bus.data_in[6:0];

    always_comb begin
        phase_d = phase_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        busy_d  = busy_q;
        abort_d = abort_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (phase_q)
            PhIdle: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    phase_d = PhPoll1;
                    sub_d   = SubSetup;
                    cnt_d   = SetupLd;
                    poll_d  = '0;
                    abort_d = 1'b0;
                end
            end
            PhFinish: phase_d = PhIdle;
            default: begin
                if (cnt_q != 8'd1) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    case (sub_q)
                        SubSetup: begin
                            sub_d = SubStrobe;
                            cnt_d = PulseLd;
                        end
                        SubStrobe: begin
                            sub_d = SubHold;
                            cnt_d = HoldLd;
                            if (in_poll) begin
                                busy_d = bus.data_in[7];
                                poll_d = poll_q + 8'd1;
                            end
                        end
                        SubHold: begin
                            sub_d = SubRecover;
                            cnt_d = RecoverLd;
                        end
                        default: begin
                            sub_d = SubSetup;
                            cnt_d = SetupLd;
                            if (in_poll && busy_q) begin
                                // Still busy: re-poll unless this was the last allowed read.
                                if (poll_q == MaxPolls) begin
                                    phase_d = PhFinish;
                                    abort_d = 1'b1;
                                end
                            end else begin
                                phase_d = phase_q + 3'd1;
                                poll_d  = '0;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so the pins never glitch.
    always_comb begin
        cs_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        data_oe_d  = 1'b0;
        a0_d       = a0_q;
        data_out_d = data_out_q;
        if ((phase_d == PhWaddr) || (phase_d == PhWdata)) begin
            a0_d       = (phase_d == PhWdata);
            data_out_d = (phase_d == PhWdata) ? data_d : addr_d;
            if (sub_d != SubRecover) begin
                cs_n_d    = 1'b0;
                data_oe_d = 1'b1;
                wr_n_d    = (sub_d != SubStrobe);
            end
        end else if ((phase_d == PhPoll1) || (phase_d == PhPoll2)) begin
            a0_d = 1'b1;
            if (sub_d != SubRecover) begin
                cs_n_d = 1'b0;
                rd_n_d = (sub_d != SubStrobe);
            end
        end
        req_ready_d = (phase_d == PhIdle);
        done_d      = (phase_d == PhFinish);
        err_d       = (phase_d == PhFinish) && abort_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PhIdle;
            sub_q       <= SubSetup;
            cnt_q       <= '0;
            poll_q      <= '0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            poll_q      <= poll_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            a0_q        <= a0_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.wr_n        = wr_n_q;
    assign bus.rd_n        = rd_n_q;
    assign bus.a0          = a0_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_oe     = data_oe_q;

endmodule

// File: tb/tb_ym_bus_writer.sv
// Scoreboard bench for ym_bus_writer: two instances (default timing, and all-1 timing with
// MAX_POLLS=3) driven with directed and random requests against a timing model.
module tb_ym_bus_writer;

    localparam int AS = 2, AP = 4, AH = 2, AR = 4, AMAX = 64;
    localparam int BS = 1, BP = 1, BH = 1, BR = 1, BMAX = 3;

    typedef struct {
        int         done_ofs;
        int         err;
        int         n_wr;
        int         n_rd;
        int         wr0_ofs;
        int         wr1_ofs;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    ym_bus_writer_if if_a ();
    ym_bus_writer_if if_b ();

    ym_bus_writer #(
        .SETUP_CYC(AS), .PULSE_CYC(AP), .HOLD_CYC(AH), .RECOVER_CYC(AR), .MAX_POLLS(AMAX)
    ) u_a (
        .clk(clk),
        .rst(rst),
        .bus(if_a)
    );

    ym_bus_writer #(
        .SETUP_CYC(BS), .PULSE_CYC(BP), .HOLD_CYC(BH), .RECOVER_CYC(BR), .MAX_POLLS(BMAX)
    ) u_b (
        .clk(clk),
        .rst(rst),
        .bus(if_b)
    );

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   busy0[$];
    bit   busy1[$];
    int   exp_cnt[2];

    // Monitor state, per instance
    bit         act[2];
    bit         pdone[2];
    logic       pwr[2];
    logic       prd[2];
    int         acc[2];
    int         nwr[2];
    int         nrd[2];
    int         proto[2];
    int         dones[2];
    int         wofs[2][2];
    logic       a0r[2][2];
    logic [7:0] wdr[2][2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act_v, exp_v);
        end
    endtask

    // Timing of one request from the rules: whole bus cycles of S+P+H+R clks, a poll phase
    // takes (busy reads + 1) cycles or aborts after mx reads, done one clk after the last cycle.
    function automatic exp_t model(input int s, p, h, r, mx, b1, b2,
                                   input logic [7:0] ad, dt);
        exp_t e;
        int   t;
        int   r1;
        int   r2;
        t = s + p + h + r;
        e.addr = ad;
        e.data = dt;
        e.err = 0;
        e.n_wr = 0;
        e.wr0_ofs = 0;
        e.wr1_ofs = 0;
        if (b1 >= mx) begin
            e.err = 1;
            e.n_rd = mx;
            e.done_ofs = mx * t + 1;
            return e;
        end
        r1 = b1 + 1;
        e.n_wr = 1;
        e.wr0_ofs = r1 * t + s + 1;
        if (b2 >= mx) begin
            e.err = 1;
            e.n_rd = r1 + mx;
            e.done_ofs = (r1 + 1 + mx) * t + 1;
            return e;
        end
        r2 = b2 + 1;
        e.n_wr = 2;
        e.n_rd = r1 + r2;
        e.wr1_ofs = (r1 + 1 + r2) * t + s + 1;
        e.done_ofs = (r1 + r2 + 2) * t + 1;
        return e;
    endfunction

    task automatic push_busy(input int k, input bit v);
        if (k == 0) busy0.push_back(v);
        else busy1.push_back(v);
    endtask

    task automatic queue_req(input int k, input logic [7:0] ad, dt, input int b1, b2);
        exp_t e;
        int   mx;
        int   b;
        mx = (k == 0) ? AMAX : BMAX;
        if (k == 0) e = model(AS, AP, AH, AR, AMAX, b1, b2, ad, dt);
        else e = model(BS, BP, BH, BR, BMAX, b1, b2, ad, dt);
        if (k == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        exp_cnt[k]++;
        for (int ph = 0; ph < 2; ph++) begin
            b = (ph == 0) ? b1 : b2;
            for (int i = 0; i < b && i < mx; i++) push_busy(k, 1'b1);
            if (b >= mx) return;
            push_busy(k, 1'b0);
        end
    endtask

    // Synth core stand-in: presents the next scheduled status byte when a read strobe starts.
    initial begin
        bit b;
        if_a.data_in = 8'h00;
        forever begin
            @(negedge if_a.rd_n);
            b = (busy0.size() > 0) ? busy0.pop_front() : 1'b0;
            if_a.data_in = {b, 7'($urandom)};
        end
    end

    initial begin
        bit b;
        if_b.data_in = 8'h00;
        forever begin
            @(negedge if_b.rd_n);
            b = (busy1.size() > 0) ? busy1.pop_front() : 1'b0;
            if_b.data_in = {b, 7'($urandom)};
        end
    end

    function automatic logic rdy(input int k);
        return (k == 0) ? if_a.req_ready : if_b.req_ready;
    endfunction

    function automatic logic [15:0] outv(input int k);
        if (k == 0)
            return {if_a.req_ready, if_a.done, if_a.err_timeout, if_a.cs_n, if_a.wr_n,
                    if_a.rd_n, if_a.a0, if_a.data_oe, if_a.data_out};
        return {if_b.req_ready, if_b.done, if_b.err_timeout, if_b.cs_n, if_b.wr_n,
                if_b.rd_n, if_b.a0, if_b.data_oe, if_b.data_out};
    endfunction

    task automatic set_req(input int k, input logic v, input logic [7:0] ad, dt);
        if (k == 0) begin
            if_a.req_valid = v;
            if_a.req_addr  = ad;
            if_a.req_data  = dt;
        end else begin
            if_b.req_valid = v;
            if_b.req_addr  = ad;
            if_b.req_data  = dt;
        end
    endtask

    // Returns #1 after the acceptance edge (start of cycle 1).
    task automatic wait_accept(input int k);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy(k)) break;
            n++;
            if (n > 3000) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (dones[k] < exp_cnt[k]) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                chk("done_timeout", dones[k], exp_cnt[k]);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] ad, dt, input int b1, b2);
        queue_req(k, ad, dt, b1, b2);
        set_req(k, 1'b1, ad, dt);
        wait_accept(k);
        // Scribble on the request inputs; the latched copy must be used.
        set_req(k, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic mon(input int k, input logic r, v, rd_y, dn, er, csn, wrn, rdn, a,
                       input logic [7:0] dout, input logic oe);
        exp_t  e;
        int    ofs;
        int    qs;
        string p;
        p = (k == 0) ? "a" : "b";
        if (r) begin
            act[k] = 1'b0;
            pdone[k] = 1'b0;
            pwr[k] = 1'b1;
            prd[k] = 1'b1;
            return;
        end
        if (pdone[k] && !rd_y) proto[k]++;
        pdone[k] = 1'b0;
        if (er && !dn) proto[k]++;
        if (!wrn && !rdn) proto[k]++;
        if (act[k]) begin
            if (rd_y) proto[k]++;
            ofs = cyc - acc[k];
            if (!wrn) begin
                if (pwr[k]) begin
                    if (nwr[k] < 2) begin
                        wofs[k][nwr[k]] = ofs;
                        a0r[k][nwr[k]] = a;
                        wdr[k][nwr[k]] = dout;
                    end
                    nwr[k]++;
                end else if (nwr[k] >= 1 && nwr[k] <= 2) begin
                    if (a != a0r[k][nwr[k]-1] || dout != wdr[k][nwr[k]-1]) proto[k]++;
                end
                if (csn || !oe) proto[k]++;
            end
            if (!rdn) begin
                if (prd[k]) nrd[k]++;
                if (csn || oe || !a) proto[k]++;
            end
            if (dn) begin
                dones[k]++;
                act[k] = 1'b0;
                pdone[k] = 1'b1;
                qs = (k == 0) ? exp_q0.size() : exp_q1.size();
                chk({p, "_exp_available"}, (qs > 0) ? 1 : 0, 1);
                if (qs > 0) begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk({p, "_done_ofs"}, ofs, e.done_ofs);
                    chk({p, "_err_timeout"}, int'(er), e.err);
                    chk({p, "_n_wr"}, nwr[k], e.n_wr);
                    chk({p, "_n_rd"}, nrd[k], e.n_rd);
                    if (e.n_wr >= 1 && nwr[k] >= 1) begin
                        chk({p, "_waddr_ofs"}, wofs[k][0], e.wr0_ofs);
                        chk({p, "_waddr_a0"}, int'(a0r[k][0]), 0);
                        chk({p, "_waddr_val"}, int'(wdr[k][0]), int'(e.addr));
                    end
                    if (e.n_wr >= 2 && nwr[k] >= 2) begin
                        chk({p, "_wdata_ofs"}, wofs[k][1], e.wr1_ofs);
                        chk({p, "_wdata_a0"}, int'(a0r[k][1]), 1);
                        chk({p, "_wdata_val"}, int'(wdr[k][1]), int'(e.data));
                    end
                end
            end
        end else begin
            if (dn) begin
                dones[k]++;
                chk({p, "_done_while_idle"}, int'(dn), 0);
            end
            if (!csn || !wrn || !rdn || oe) proto[k]++;
        end
        if (v && rd_y) begin
            if (act[k]) proto[k]++;
            act[k] = 1'b1;
            acc[k] = cyc;
            nwr[k] = 0;
            nrd[k] = 0;
        end
        pwr[k] = wrn;
        prd[k] = rdn;
    endtask

    initial begin
        pwr = '{1'b1, 1'b1};
        prd = '{1'b1, 1'b1};
        forever begin
            @(negedge clk);
            mon(0, rst, if_a.req_valid, if_a.req_ready, if_a.done, if_a.err_timeout, if_a.cs_n,
                if_a.wr_n, if_a.rd_n, if_a.a0, if_a.data_out, if_a.data_oe);
            mon(1, rst, if_b.req_valid, if_b.req_ready, if_b.done, if_b.err_timeout, if_b.cs_n,
                if_b.wr_n, if_b.rd_n, if_b.a0, if_b.data_out, if_b.data_oe);
        end
    end

    initial begin
        int         bad[2];
        int         d_before;
        int         k;
        logic [7:0] sa[3];
        logic [7:0] sd[3];
        rst = 1'b1;
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_outputs", int'(outv(0)), 'h1C00);
        chk("b_reset_outputs", int'(outv(1)), 'h1C00);
        @(posedge clk);
        #1 rst = 1'b0;

        bad = '{0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++)
                if (outv(j) != ((i == 0) ? 16'h1C00 : 16'h9C00)) bad[j]++;
        end
        chk("a_idle_outputs", bad[0], 0);
        chk("b_idle_outputs", bad[1], 0);
        @(posedge clk);
        #1;

        // Directed: plain write, then busy for three POLL2 reads, then a POLL1 timeout.
        send(0, 8'h20, 8'hC7, 0, 0);
        wait_done(0);
        send(0, 8'h3A, 8'h5E, 0, 3);
        wait_done(0);
        send(1, 8'h08, 8'h78, 3, 0);
        wait_done(1);

        // Reset during the WADDR strobe: bus returns to idle next cycle, no done.
        d_before = dones[0];
        send(0, 8'h55, 8'hAA, 0, 0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        exp_q0.delete();
        busy0.delete();
        exp_cnt[0]--;
        @(negedge clk);
        chk("a_wr_low_before_rst", int'(if_a.wr_n), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_outputs_after_rst", int'(outv(0)), 'h1C00);
        repeat (60) @(negedge clk);
        chk("a_no_done_after_rst", dones[0], d_before);
        @(posedge clk);
        #1;
        send(0, 8'h21, 8'h3C, 0, 0);
        wait_done(0);

        // req_valid held high across three queued requests.
        d_before = dones[1];
        for (int j = 0; j < 3; j++) begin
            sa[j] = 8'($urandom);
            sd[j] = 8'($urandom);
            queue_req(1, sa[j], sd[j], 0, 0);
        end
        set_req(1, 1'b1, sa[0], sd[0]);
        for (int j = 0; j < 3; j++) begin
            wait_accept(1);
            if (j < 2) set_req(1, 1'b1, sa[j+1], sd[j+1]);
            else set_req(1, 1'b0, 8'h00, 8'h00);
        end
        wait_done(1);
        chk("b_stream_dones", dones[1] - d_before, 3);

        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(0, 1));
            send(k, 8'($urandom), 8'($urandom), int'($urandom_range(0, (k == 0) ? 2 : 4)),
                 int'($urandom_range(0, (k == 0) ? 2 : 4)));
            wait_done(k);
        end

        repeat (5) @(negedge clk);
        chk("a_protocol_violations", proto[0], 0);
        chk("b_protocol_violations", proto[1], 0);
        chk("a_done_total", dones[0], exp_cnt[0]);
        chk("b_done_total", dones[1], exp_cnt[1]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
